// File: rtl/letter_scroll_display.sv
// rtl/letter_scroll_display.sv - multiplexed 7-segment letter display with scrolling message buffer
// Codes are appended through a valid/ready port; messages longer than DIGITS scroll as a marquee.
module letter_scroll_display #(
  parameter int DIGITS      = 4,
  parameter int MSG_DEPTH   = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 50000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [4:0]                     wr_code,
  input  logic                           clear,
  input  logic                           scroll_en,
  output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
  output logic [0:6]                     seg,
  output logic [DIGITS-1:0]              an
);

  localparam int LW   = $clog2(MSG_DEPTH + 1);
  localparam int SUMW = LW + 1;
  localparam int AW   = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [4:0]      msg_buf [MSG_DEPTH];
  logic            run;
  logic [LW-1:0]   ofs;
  logic [RW-1:0]   ref_cnt;
  logic [SW-1:0]   scroll_cnt;
  logic [DW-1:0]   sel;
  logic            full;
  logic            wr_fire;
  logic            long_msg;
  logic [SUMW-1:0] sum;
  logic [AW-1:0]   idx;
  logic [4:0]      code;

  function automatic logic [0:6] glyph(input logic [4:0] c);
    case (c)
      5'd0:    glyph = 7'b1111111;
      5'd1:    glyph = 7'b0001000;
      5'd2:    glyph = 7'b1100000;
      5'd3:    glyph = 7'b0110001;
      5'd4:    glyph = 7'b1000010;
      5'd5:    glyph = 7'b0110000;
      5'd6:    glyph = 7'b0111000;
      5'd7:    glyph = 7'b0100001;
      5'd8:    glyph = 7'b1101000;
      5'd9:    glyph = 7'b1000011;
      5'd10:   glyph = 7'b1110001;
      5'd11:   glyph = 7'b1101010;
      5'd12:   glyph = 7'b1100010;
      5'd13:   glyph = 7'b0011000;
      5'd14:   glyph = 7'b0001100;
      5'd15:   glyph = 7'b1111010;
      5'd16:   glyph = 7'b0100100;
      5'd17:   glyph = 7'b1000001;
      5'd18:   glyph = 7'b1000100;
      default: glyph = 7'b0101010;
    endcase
  endfunction

  // run gates wr_ready so the port stays closed until the first edge after reset
  assign full     = (msg_len == LW'(MSG_DEPTH));
  assign wr_ready = run && !full && !clear;
  assign wr_fire  = wr_valid && wr_ready;
  assign long_msg = (msg_len > LW'(DIGITS));

  // ofs < msg_len and sel < DIGITS < msg_len, so one conditional subtract gives the modulo
  always_comb begin
    sum  = {1'b0, ofs} + SUMW'(sel);
    idx  = (sum >= {1'b0, msg_len}) ? AW'(sum - {1'b0, msg_len}) : AW'(sum);
    code = 5'd0;
    if (long_msg)
      code = msg_buf[idx];
    else if (LW'(sel) < msg_len)
      code = msg_buf[AW'(sel)];
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      msg_buf[AW'(msg_len)] <= wr_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      msg_len    <= '0;
      ofs        <= '0;
      ref_cnt    <= '0;
      scroll_cnt <= '0;
      sel        <= '0;
      seg        <= 7'b1111111;
      an         <= '1;
    end else begin
      run <= 1'b1;

      // outputs reflect the digit selected before this edge, so an and seg always agree
      an  <= ~(DIGITS'(1) << sel);
      seg <= glyph(code);

      if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        sel     <= (sel == DW'(DIGITS - 1)) ? '0 : sel + DW'(1);
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end

      if (clear) begin
        msg_len    <= '0;
        ofs        <= '0;
        scroll_cnt <= '0;
      end else begin
        if (wr_fire)
          msg_len <= msg_len + LW'(1);

        if (scroll_en) begin
          if (scroll_cnt == SW'(SCROLL_DIV - 1)) begin
            scroll_cnt <= '0;
            if (long_msg)
              ofs <= (ofs == msg_len - LW'(1)) ? '0 : ofs + LW'(1);
          end else begin
            scroll_cnt <= scroll_cnt + SW'(1);
          end
        end

        if (!long_msg)
          ofs <= '0;
      end
    end
  end

endmodule

// File: tb/tb_letter_scroll_display.sv
// tb/tb_letter_scroll_display.sv - self-checking bench for letter_scroll_display
// Queue-based reference model plus literal glyph pins; outputs compared every negedge.
module tb_letter_scroll_display;

  localparam int DIGITS = 4;
  localparam int DEPTH  = 8;
  localparam int RD     = 4;
  localparam int SD     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_code;
  logic       clear;
  logic       scroll_en;
  logic [3:0] msg_len;
  logic [0:6] seg;
  logic [3:0] an;

  always #5 clk = ~clk;

  letter_scroll_display #(
    .DIGITS(DIGITS), .MSG_DEPTH(DEPTH), .REFRESH_DIV(RD), .SCROLL_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_code(wr_code),
    .clear(clear), .scroll_en(scroll_en), .msg_len(msg_len), .seg(seg), .an(an)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int q[$];
  int ofs     = 0;
  int en_cnt  = 0;
  int nedge   = 0;
  int d_sel   = 0;
  int old_len = 0;
  bit m_ready = 1'b0;
  logic [6:0] exp_seg = 7'h7f;
  logic [3:0] exp_an  = 4'hf;
  bit checking = 1'b0;
  logic [6:0] cap [4];

  function automatic logic [6:0] tglyph(input int c);
    case (c)
      0:  return 7'b1111111;
      1:  return 7'b0001000;
      2:  return 7'b1100000;
      3:  return 7'b0110001;
      4:  return 7'b1000010;
      5:  return 7'b0110000;
      6:  return 7'b0111000;
      7:  return 7'b0100001;
      8:  return 7'b1101000;
      9:  return 7'b1000011;
      10: return 7'b1110001;
      11: return 7'b1101010;
      12: return 7'b1100010;
      13: return 7'b0011000;
      14: return 7'b0001100;
      15: return 7'b1111010;
      16: return 7'b0100100;
      17: return 7'b1000001;
      18: return 7'b1000100;
      default: return 7'b0101010;
    endcase
  endfunction

  function automatic int model_code(input int k);
    int len;
    len = q.size();
    if (len <= DIGITS) return (k < len) ? q[k] : 0;
    return q[(ofs + k) % len];
  endfunction

  function automatic bit model_ready();
    return (rst === 1'b0) && (nedge > 0) && (q.size() < DEPTH) && !clear;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: digit on screen follows elapsed edges; scroll steps every SD enabled edges
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      ofs = 0; en_cnt = 0; nedge = 0;
      exp_seg = 7'h7f; exp_an = 4'hf;
    end else begin
      d_sel   = (nedge / RD) % DIGITS;
      exp_an  = ~(4'b0001 << d_sel);
      exp_seg = tglyph(model_code(d_sel));
      m_ready = model_ready();
      old_len = q.size();
      if (clear) begin
        q.delete();
        ofs = 0; en_cnt = 0;
      end else begin
        if (wr_valid && m_ready) q.push_back(int'(wr_code));
        if (scroll_en) begin
          en_cnt++;
          if (en_cnt == SD) begin
            en_cnt = 0;
            if (old_len > DIGITS) ofs = (ofs + 1) % old_len;
          end
        end
      end
      nedge++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("an", 32'(an), 32'(exp_an));
      chk("msg_len", 32'(msg_len), q.size());
      chk("wr_ready", 32'(wr_ready), 32'(model_ready()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic put(input int c);
    wr_valid = 1'b1;
    wr_code  = 5'(c);
    cyc(1);
    wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic capture();
    for (int k = 0; k < DIGITS; k++) cap[k] = 7'h00;
    for (int i = 0; i < DIGITS * RD + RD; i++) begin
      @(negedge clk);
      for (int k = 0; k < DIGITS; k++)
        if (an == ~(4'b0001 << k)) cap[k] = seg;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; clear = 1'b0; scroll_en = 1'b0; wr_code = 5'd0;
    #22;
    rst = 1'b0;
    checking = 1'b1;
    cyc(1);
    chk("first_an", 32'(an), 32'b1110);
    chk("first_ready", 32'(wr_ready), 32'd1);
    chk("first_len", 32'(msg_len), 32'd0);
    cyc(4);
    chk("second_an", 32'(an), 32'b1101);

    put(1); put(2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_len", 32'(msg_len), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rerel_an", 32'(an), 32'b1110);

    scroll_en = 1'b1;
    put(8); put(5); put(10); put(12);
    cyc(500);
    capture();
    chk("model_helo", 32'(tglyph(model_code(3))), 32'b1100010);
    chk("helo_d0", 32'(cap[0]), 32'b1101000);
    chk("helo_d1", 32'(cap[1]), 32'b0110000);
    chk("helo_d2", 32'(cap[2]), 32'b1110001);
    chk("helo_d3", 32'(cap[3]), 32'b1100010);

    scroll_en = 1'b0;
    do_clear();
    for (int i = 1; i <= 6; i++) put(i);
    scroll_en = 1'b1;
    cyc(66);
    capture();
    chk("ofs1_d0", 32'(cap[0]), 32'b1100000);
    chk("ofs1_d1", 32'(cap[1]), 32'b0110001);
    cyc(172);
    capture();
    chk("ofs4_d3", 32'(cap[3]), 32'b1100000);
    chk("ofs4_d0", 32'(cap[0]), 32'b0110000);
    cyc(108);
    capture();
    chk("ofs0_d0", 32'(cap[0]), 32'b0001000);

    scroll_en = 1'b0;
    do_clear();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_code  = 5'(i + 1);
      cyc(1);
    end
    chk("full_ready", 32'(wr_ready), 32'd0);
    chk("full_len", 32'(msg_len), 32'd8);
    wr_valid = 1'b0;
    capture();
    chk("full_d3", 32'(cap[3]), 32'b1000010);

    clear = 1'b1; wr_valid = 1'b1; wr_code = 5'd3;
    #1;
    chk("clr_ready", 32'(wr_ready), 32'd0);
    cyc(1);
    clear = 1'b0; wr_valid = 1'b0;
    chk("clr_len", 32'(msg_len), 32'd0);
    capture();
    for (int k = 0; k < DIGITS; k++) chk("clr_blank", 32'(cap[k]), 32'h7f);

    do_clear();
    put(25); put(0);
    capture();
    chk("inv_d0", 32'(cap[0]), 32'b0101010);
    chk("blank_d1", 32'(cap[1]), 32'b1111111);

    do_clear();
    for (int i = 1; i <= 6; i++) put(i);
    cyc(300);
    capture();
    chk("frozen_d0", 32'(cap[0]), 32'b0001000);
    chk("frozen_d1", 32'(cap[1]), 32'b1100000);

    scroll_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_code  = 5'($urandom_range(0, 31));
      clear    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) scroll_en = ~scroll_en;
      cyc(1);
    end
    wr_valid = 1'b0; clear = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
